param_shifter: RTL

Parametrised multi-mode shift register for the lab datapath. It is the generalised successor to the fixed 8-bit arithmetic-shift register. It loads a WIDTH-bit word, then performs logical, arithmetic or rotate shifts by a requested amount, stepping one bit position per clock. A start/busy/done handshake lets FSM-driven lab tops sequence it.

---
 rtl/shifter_pkg.sv | 25 ++
 rtl/shift_step.sv | 67 ++++++
 rtl/param_shifter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// ---------------------------------------------------------------------------
// shifter_pkg
// Shared types for the parametrised shift register:
//   shift_op_t - operation codes presented on the op port
//   state_t    - control FSM states (idle / multi-step shifting)
// ---------------------------------------------------------------------------
package shifter_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHL  = 3'd2,
    OP_SHR  = 3'd3,
    OP_ASR  = 3'd4,
    OP_ROL  = 3'd5,
    OP_ROR  = 3'd6,
    OP_RSVD = 3'd7
  } shift_op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Purely combinational single-position shift/rotate function.
// Optional feature macro: PARAM_SHIFTER_ROTATE_EN (builds ROL/ROR; when
// undefined, rotate codes fall through to the hold behaviour).
// Ports:
//   q        in  WIDTH  current register value
//   op       in  3      operation (shift_op_t)
//   ser_in   in  1      fill bit for logical shifts
//   next_q   out WIDTH  value after one step
//   out_bit  out 1      bit shifted or rotated out by this step
//   is_shift out 1      op moves bits (so ser_out should be updated)
// ---------------------------------------------------------------------------
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  shift_op_t        op,
  input  logic             ser_in,
  output logic [WIDTH-1:0] next_q,
  output logic             out_bit,
  output logic             is_shift
);

  // Default is "no movement"; only real shift ops override it, which is what
  // makes reserved (and, without rotate support, rotate) codes act as HOLD.
  always_comb begin
    next_q   = q;
    out_bit  = 1'b0;
    is_shift = 1'b0;
    case (op)
      OP_SHL: begin
        next_q   = {q[WIDTH-2:0], ser_in};
        out_bit  = q[WIDTH-1];
        is_shift = 1'b1;
      end
      OP_SHR: begin
        next_q   = {ser_in, q[WIDTH-1:1]};
        out_bit  = q[0];
        is_shift = 1'b1;
      end
      OP_ASR: begin
        // Sign fill comes from the live register MSB.
        next_q   = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit  = q[0];
        is_shift = 1'b1;
      end
`ifdef PARAM_SHIFTER_ROTATE_EN
      OP_ROL: begin
        next_q   = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit  = q[WIDTH-1];
        is_shift = 1'b1;
      end
      OP_ROR: begin
        next_q   = {q[0], q[WIDTH-1:1]};
        out_bit  = q[0];
        is_shift = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/param_shifter.sv
// ---------------------------------------------------------------------------
// param_shifter
// Parametrised multi-mode shift register. Loads a WIDTH-bit word, then does
// logical / arithmetic / rotate shifts stepping one bit per clock, with a
// start/busy/done handshake.
// Optional feature macro: PARAM_SHIFTER_ROTATE_EN (enables ROL/ROR; without
// it ops 5 and 6 behave as HOLD).
// Parameters: WIDTH (>= 2), AMT_W (2**AMT_W > WIDTH)
// Ports:
//   clock     in  1      rising-edge clock
//   reset_n   in  1      synchronous active-low reset
//   start     in  1      request strobe, sampled only when idle
//   op        in  3      operation code (shift_op_t), sampled with start
//   amount    in  AMT_W  number of single-bit steps, sampled with start
//   load_val  in  WIDTH  parallel load data, sampled with start
//   ser_in    in  1      logical-shift fill bit, sampled live every step
//   q         out WIDTH  register contents
//   ser_out   out 1      last bit shifted/rotated out (held between ops)
//   busy      out 1      multi-step shift in progress
//   done      out 1      one-cycle completion pulse
// ---------------------------------------------------------------------------
module param_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

  state_t           state, state_next;
  shift_op_t        op_r, op_next, op_in, op_sel;
  logic [AMT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] q_r, q_next;
  logic             ser_r, ser_next;
  logic             busy_r, busy_next;
  logic             done_r, done_next;

  logic [WIDTH-1:0] step_q;
  logic             step_bit;
  logic             step_shift;

  assign op_in = shift_op_t'(op);

  // While idle the step function looks at the requested op so the first step
  // lands on the accept edge; during SHIFT it uses the latched op.
  assign op_sel = (state == ST_IDLE) ? op_in : op_r;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .q        (q_r),
    .op       (op_sel),
    .ser_in   (ser_in),
    .next_q   (step_q),
    .out_bit  (step_bit),
    .is_shift (step_shift)
  );

  // Next-state and datapath decode. busy/done are recomputed every cycle, so
  // done is naturally a single-cycle pulse unless a new request is accepted.
  always_comb begin
    state_next = state;
    op_next    = op_r;
    cnt_next   = cnt;
    q_next     = q_r;
    ser_next   = ser_r;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          op_next = op_in;
          if (step_shift) begin
            if (amount == '0) begin
              done_next = 1'b1;
            end else begin
              q_next   = step_q;
              ser_next = step_bit;
              if (amount == CNT_ONE) begin
                done_next = 1'b1;
              end else begin
                cnt_next   = amount - CNT_ONE;
                state_next = ST_SHIFT;
                busy_next  = 1'b1;
              end
            end
          end else begin
            if (op_in == OP_LOAD) begin
              q_next = load_val;
            end
            done_next = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        q_next   = step_q;
        ser_next = step_bit;
        cnt_next = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else begin
          busy_next = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Register bank; reset wins over any operation in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      op_r   <= OP_HOLD;
      cnt    <= '0;
      q_r    <= '0;
      ser_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_next;
      op_r   <= op_next;
      cnt    <= cnt_next;
      q_r    <= q_next;
      ser_r  <= ser_next;
      busy_r <= busy_next;
      done_r <= done_next;
    end
  end

  assign q       = q_r;
  assign ser_out = ser_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule
